load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Sits between the ALU/control path and the byte-addressed data memory. Turns one
//  load/store request (funct3 size/sign, byte address) into aligned word accesses
//  with byte enables, and splits word-crossing accesses into two accesses.
//  Returns sign/zero-extended load data with a one-cycle completion pulse.
//  Core waits on req_ready/rsp_valid.
// PARAMETERS
//  MISALIGN_EN  1  1: split word-crossing accesses; 0: reject them with rsp_err
// PORTS
//  clk        in   1   clock, all state on posedge
//  rst        in   1   synchronous, active-high reset
//  req_valid  in   1   request present
//  req_we     in   1   1 = store, 0 = load
//  req_funct3 in   3   000 B, 001 H, 010 W, 100 BU, 101 HU (stores use size bits only)
//  req_addr   in   32  byte address (word_t)
//  req_wdata  in   32  store data, right-aligned
//  req_ready  out  1   high only in IDLE; request accepted when valid&&ready
//  rsp_valid  out  1   one-cycle completion pulse
//  rsp_rdata  out  32  extended load data; 0 for stores and errors
//  rsp_err    out  1   qualifies rsp_valid: illegal funct3 or rejected misalign
//  mem_addr   out  32  word-aligned address (addr[1:0]=00)
//  mem_wdata  out  32  lane-shifted store data
//  mem_be     out  4   byte enables; bit i = byte lane i, little endian
//  mem_we     out  1   write strobe, written at the same posedge
//  mem_re     out  1   read strobe; mem_rdata valid in the following cycle
//  mem_rdata  in   32  read data
// BEHAVIOUR
//  - Reset (sync, rst high at posedge): state=IDLE; rsp_valid=0; rsp_rdata=0;
//    rsp_err=0; mem_we=mem_re=0; mem_be=0; mem_addr=mem_wdata=0.
//    req_ready=1 from the first cycle after reset. Requests seen while rst=1 are ignored.
//  - FSM: IDLE -> REQ0 -> (load) RD0 -> [REQ1 -> (load) RD1] -> RESP -> IDLE.
//    Illegal or rejected request: IDLE -> RESP directly. RESP lasts exactly one cycle.
//  - Moore outputs: rsp_valid=(state==RESP). mem_* is driven only in REQ0/REQ1 and is 0 elsewhere.
//  - Accept in cycle T:
//    aligned store -> mem_we at T+1, rsp at T+2; split store -> T+1, T+2, rsp T+3;
//    aligned load  -> mem_re at T+1, capture T+2, rsp T+3;
//    split load    -> re T+1, capture T+2, re T+3, capture T+4, rsp T+5;
//    error         -> rsp at T+1.
//  - Alignment math: off=addr[1:0]; mask=1/3/F by size.
//    be8=mask<<off; wd64=wdata<<(8*off).
//    REQ0: addr&~3, be8[3:0], wd64[31:0]. REQ1: (addr&~3)+4 (wraps mod 2^32), be8[7:4], wd64[63:32].
//    REQ1 is needed iff be8[7:4]!=0.
//  - Load data: rd64={rd1,rd0} (rd1=0 if unsplit) >> 8*off. Extend from bit 7/15 for B/H; zero-extend for BU/HU.
//  - Illegal funct3 (011,110,111; also any store funct3[2]=1): no mem access, rsp_err=1.
//    MISALIGN_EN=0 with a crossing access: no mem access, rsp_err=1.
//  - Reset mid-operation: IDLE at the next edge, no rsp_valid pulse.
//    A first store half already written is not rolled back.
//  - req_* is sampled only at accept. Later changes to inputs do not affect an access in flight.
// STRUCTURE
//  - RISCV_pkg: word_t, lsu_state_t enum, F3_LB..F3_LHU constants, size-mask function.
//  - Sub-module lsu_align (combinational): off/funct3/wdata -> be8, wd64; rd64/funct3 -> extended rdata.
//    The FSM and request/capture registers stay in load_store_unit.
// TESTING
//  1. SW 0xDEADBEEF @0x08 -> T+1: we=1 addr=0x08 be=1111 wdata=DEADBEEF; T+2: rsp_valid=1 err=0.
//  2. word@0x04=0x123480FF; LB @0x05 -> rdata=0xFFFFFF80 at T+3; LBU @0x05 -> 0x00000080.
//  3. SW 0xAABBCCDD @0x06 -> T+1: addr 0x04 be 1100 wd 0xCCDD0000;
//     T+2: addr 0x08 be 0011 wd 0x0000AABB; rsp T+3.
//  4. word@4=0x11223344, word@8=0x55667788; LH @0x07 -> two reads; rdata=0xFFFF8811 at T+5.
//  5. funct3=011 -> no mem_re/we, rsp_valid=1 err=1 rdata=0 at T+1.
//     With MISALIGN_EN=0, LW @0x02 -> same response.
//  6. rst=1 during RD0 of a split load -> next cycle IDLE, req_ready=1, no rsp_valid.
//     LW @0xFFFFFFFE -> second access at addr 0x00000000.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared types, FSM state codes and funct3 helpers for the load/store unit.
// Used by both the FSM top and the combinational alignment datapath.
package load_store_unit_pkg;

    typedef logic [31:0] word_t;
    typedef logic [2:0]  lsu_state_t;

    localparam lsu_state_t ST_IDLE = 3'd0;
    localparam lsu_state_t ST_REQ0 = 3'd1;
    localparam lsu_state_t ST_RD0  = 3'd2;
    localparam lsu_state_t ST_REQ1 = 3'd3;
    localparam lsu_state_t ST_RD1  = 3'd4;
    localparam lsu_state_t ST_RESP = 3'd5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Byte mask of an access from the funct3 size bits; 11 has no legal size.
    function automatic logic [3:0] size_mask(input logic [1:0] size);
        logic [3:0] mask;
        case (size)
            2'b00:   mask = 4'b0001;
            2'b01:   mask = 4'b0011;
            2'b10:   mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

    // Unsigned variants only make sense for loads.
    function automatic logic f3_illegal(input logic [2:0] f3, input logic we);
        logic bad;
        case (f3)
            F3_LB, F3_LH, F3_LW: bad = 1'b0;
            F3_LBU, F3_LHU:      bad = we;
            default:             bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational lane alignment: byte enables and shifted store data across a
// two-word window, plus right-shift and sign/zero extension of load data.
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    input  word_t       wdata,
    input  logic [63:0] rd64,
    output logic [7:0]  be8,
    output logic [63:0] wd64,
    output word_t       rdata
);

    logic [4:0] shamt_s;
    word_t      rsh_s;

    // Store lanes and load extraction share the same byte offset.
    always_comb begin
        shamt_s = {off, 3'b000};
        be8     = {4'b0000, size_mask(funct3[1:0])} << off;
        wd64    = {32'h0000_0000, wdata} << shamt_s;
        rsh_s   = word_t'(rd64 >> shamt_s);
        case (funct3)
            F3_LB:   rdata = {{24{rsh_s[7]}}, rsh_s[7:0]};
            F3_LH:   rdata = {{16{rsh_s[15]}}, rsh_s[15:0]};
            F3_LW:   rdata = rsh_s;
            F3_LBU:  rdata = {24'h00_0000, rsh_s[7:0]};
            F3_LHU:  rdata = {16'h0000, rsh_s[15:0]};
            default: rdata = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request, issues one or two aligned word accesses
// and returns an extended load result with a single-cycle completion pulse.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter bit MISALIGN_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  word_t       req_addr,
    input  word_t       req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output word_t       rsp_rdata,
    output logic        rsp_err,
    output word_t       mem_addr,
    output word_t       mem_wdata,
    output logic [3:0]  mem_be,
    output logic        mem_we,
    output logic        mem_re,
    input  word_t       mem_rdata
);

    lsu_state_t  state_r, state_nxt_s;
    word_t       addr_r, wdata_r, rd0_r;
    logic [2:0]  funct3_r;
    logic        we_r, split_r;

    word_t       sel_addr_s, sel_wdata_s, ext_rdata_s;
    logic [2:0]  sel_funct3_s;
    logic        sel_we_s;
    logic [7:0]  be8_s;
    logic [63:0] wd64_s, rd64_s;
    logic        cross_s, reject_s, accept_s;

    word_t       mem_addr_nxt_s, mem_wdata_nxt_s, rsp_rdata_nxt_s;
    logic [3:0]  mem_be_nxt_s;
    logic        mem_we_nxt_s, mem_re_nxt_s, rsp_err_nxt_s;

    // In IDLE the aligner looks at the live request, afterwards at the captured one.
    always_comb begin
        if (state_r == ST_IDLE) begin
            sel_addr_s   = req_addr;
            sel_wdata_s  = req_wdata;
            sel_funct3_s = req_funct3;
            sel_we_s     = req_we;
        end else begin
            sel_addr_s   = addr_r;
            sel_wdata_s  = wdata_r;
            sel_funct3_s = funct3_r;
            sel_we_s     = we_r;
        end
        case (state_r)
            ST_RD0:  rd64_s = {32'h0000_0000, mem_rdata};
            ST_RD1:  rd64_s = {mem_rdata, rd0_r};
            default: rd64_s = 64'h0;
        endcase
        accept_s = req_valid && (state_r == ST_IDLE);
        cross_s  = |be8_s[7:4];
        reject_s = f3_illegal(req_funct3, req_we) || (!MISALIGN_EN && cross_s);
    end

    lsu_align u_align (
        .off    (sel_addr_s[1:0]),
        .funct3 (sel_funct3_s),
        .wdata  (sel_wdata_s),
        .rd64   (rd64_s),
        .be8    (be8_s),
        .wd64   (wd64_s),
        .rdata  (ext_rdata_s)
    );

    // Next-state logic of the access sequencer.
    always_comb begin
        state_nxt_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = reject_s ? ST_RESP : ST_REQ0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ0: begin
                if (we_r) begin
                    state_nxt_s = split_r ? ST_REQ1 : ST_RESP;
                end else begin
                    state_nxt_s = ST_RD0;
                end
            end
            ST_RD0:  state_nxt_s = split_r ? ST_REQ1 : ST_RESP;
            ST_REQ1: state_nxt_s = we_r ? ST_RESP : ST_RD1;
            ST_RD1:  state_nxt_s = ST_RESP;
            ST_RESP: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Outputs are precomputed from the next state so they register as Moore outputs.
    always_comb begin
        mem_addr_nxt_s  = 32'h0000_0000;
        mem_wdata_nxt_s = 32'h0000_0000;
        mem_be_nxt_s    = 4'b0000;
        mem_we_nxt_s    = 1'b0;
        mem_re_nxt_s    = 1'b0;
        if (state_nxt_s == ST_REQ0) begin
            mem_addr_nxt_s  = {sel_addr_s[31:2], 2'b00};
            mem_wdata_nxt_s = wd64_s[31:0];
            mem_be_nxt_s    = be8_s[3:0];
            mem_we_nxt_s    = sel_we_s;
            mem_re_nxt_s    = !sel_we_s;
        end else if (state_nxt_s == ST_REQ1) begin
            mem_addr_nxt_s  = {sel_addr_s[31:2], 2'b00} + 32'd4;
            mem_wdata_nxt_s = wd64_s[63:32];
            mem_be_nxt_s    = be8_s[7:4];
            mem_we_nxt_s    = sel_we_s;
            mem_re_nxt_s    = !sel_we_s;
        end else begin
            mem_addr_nxt_s  = 32'h0000_0000;
        end
        // RESP reached straight from IDLE only happens for rejected requests.
        if (state_nxt_s == ST_RESP) begin
            rsp_err_nxt_s   = (state_r == ST_IDLE);
            rsp_rdata_nxt_s = ((state_r == ST_RD0) || (state_r == ST_RD1)) ? ext_rdata_s : 32'h0000_0000;
        end else begin
            rsp_err_nxt_s   = 1'b0;
            rsp_rdata_nxt_s = 32'h0000_0000;
        end
    end

    // State, request capture, first-word capture and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            addr_r    <= 32'h0000_0000;
            wdata_r   <= 32'h0000_0000;
            funct3_r  <= 3'b000;
            we_r      <= 1'b0;
            split_r   <= 1'b0;
            rd0_r     <= 32'h0000_0000;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0000_0000;
            rsp_err   <= 1'b0;
            mem_addr  <= 32'h0000_0000;
            mem_wdata <= 32'h0000_0000;
            mem_be    <= 4'b0000;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                addr_r   <= req_addr;
                wdata_r  <= req_wdata;
                funct3_r <= req_funct3;
                we_r     <= req_we;
                split_r  <= cross_s;
            end
            if (state_r == ST_RD0) begin
                rd0_r <= mem_rdata;
            end
            req_ready <= (state_nxt_s == ST_IDLE);
            rsp_valid <= (state_nxt_s == ST_RESP);
            rsp_rdata <= rsp_rdata_nxt_s;
            rsp_err   <= rsp_err_nxt_s;
            mem_addr  <= mem_addr_nxt_s;
            mem_wdata <= mem_wdata_nxt_s;
            mem_be    <= mem_be_nxt_s;
            mem_we    <= mem_we_nxt_s;
            mem_re    <= mem_re_nxt_s;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a small byte-lane memory model, one unit
// with split accesses enabled and one with them rejected.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req_valid, req_valid1;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        mem_we, mem_re;

    logic        req_ready1, rsp_valid1, rsp_err1, mem_we1, mem_re1;
    logic [31:0] rsp_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
    logic [3:0]  mem_be1;

    logic [31:0] mem [0:15];
    int n_cmp = 0;
    int n_err = 0;

    load_store_unit dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
    );

    load_store_unit #(.MISALIGN_EN(1'b0)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid1), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready1), .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1),
        .rsp_err(rsp_err1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_be(mem_be1), .mem_we(mem_we1), .mem_re(mem_re1), .mem_rdata(mem_rdata1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata1 = 32'h0000_0000;

    // Word memory indexed by addr[5:2]; read data appears the cycle after mem_re.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (mem_we && mem_be[i]) mem[mem_addr[5:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
        if (mem_re) mem_rdata <= mem[mem_addr[5:2]];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request for one cycle, then scramble the inputs while it is in flight.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d; req_valid = 1'b1;
        tick();
        req_valid = 1'b0; req_we = ~we; req_funct3 = 3'b111;
        req_addr = 32'h5555_5555; req_wdata = 32'h0000_0000;
    endtask

    task automatic wait_rsp(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk(tag, {31'd0, seen}, 32'd1);
        tick();
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        issue(1'b1, 3'b010, a, d);
        wait_rsp("setup_store_rsp");
    endtask

    initial begin
        int pulses;
        rst = 1'b1; req_valid = 1'b1; req_valid1 = 1'b0; req_we = 1'b1;
        req_funct3 = 3'b010; req_addr = 32'h0000_0010; req_wdata = 32'hFFFF_FFFF;
        tick();
        tick();
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        req_valid = 1'b0; rst = 1'b0;
        tick();
        chk("rst_req_ignored", {31'd0, mem_we}, 32'd0);

        // 1: aligned store word
        issue(1'b1, 3'b010, 32'h0000_0008, 32'hDEAD_BEEF);
        chk("sw_we", {31'd0, mem_we}, 32'd1);
        chk("sw_re", {31'd0, mem_re}, 32'd0);
        chk("sw_addr", mem_addr, 32'h0000_0008);
        chk("sw_be", {28'd0, mem_be}, 32'hF);
        chk("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("sw_busy", {31'd0, req_ready}, 32'd0);
        tick();
        chk("sw_rsp", {31'd0, rsp_valid}, 32'd1);
        chk("sw_err", {31'd0, rsp_err}, 32'd0);
        chk("sw_rdata", rsp_rdata, 32'h0);
        chk("sw_we_off", {31'd0, mem_we}, 32'd0);
        tick();
        chk("sw_rsp_pulse", {31'd0, rsp_valid}, 32'd0);
        chk("sw_ready_back", {31'd0, req_ready}, 32'd1);
        chk("sw_mem", mem[2], 32'hDEAD_BEEF);

        // 2: signed and unsigned byte loads
        store(32'h0000_0004, 32'h1234_80FF);
        issue(1'b0, 3'b000, 32'h0000_0005, 32'h0);
        chk("lb_re", {31'd0, mem_re}, 32'd1);
        chk("lb_addr", mem_addr, 32'h0000_0004);
        chk("lb_be", {28'd0, mem_be}, 32'h2);
        tick();
        chk("lb_re_off", {31'd0, mem_re}, 32'd0);
        chk("lb_no_rsp", {31'd0, rsp_valid}, 32'd0);
        tick();
        chk("lb_rsp", {31'd0, rsp_valid}, 32'd1);
        chk("lb_rdata", rsp_rdata, 32'hFFFF_FF80);
        tick();
        issue(1'b0, 3'b100, 32'h0000_0005, 32'h0);
        tick();
        tick();
        chk("lbu_rsp", {31'd0, rsp_valid}, 32'd1);
        chk("lbu_rdata", rsp_rdata, 32'h0000_0080);
        tick();

        // 3: word store crossing a word boundary
        issue(1'b1, 3'b010, 32'h0000_0006, 32'hAABB_CCDD);
        chk("ssw0_addr", mem_addr, 32'h0000_0004);
        chk("ssw0_be", {28'd0, mem_be}, 32'hC);
        chk("ssw0_wd", mem_wdata, 32'hCCDD_0000);
        chk("ssw0_we", {31'd0, mem_we}, 32'd1);
        tick();
        chk("ssw1_addr", mem_addr, 32'h0000_0008);
        chk("ssw1_be", {28'd0, mem_be}, 32'h3);
        chk("ssw1_wd", mem_wdata, 32'h0000_AABB);
        chk("ssw1_rsp_early", {31'd0, rsp_valid}, 32'd0);
        tick();
        chk("ssw_rsp", {31'd0, rsp_valid}, 32'd1);
        tick();
        chk("ssw_mem_lo", mem[1], 32'hCCDD_80FF);
        chk("ssw_mem_hi", mem[2], 32'hDEAD_AABB);

        // 4: halfword load crossing a word boundary
        store(32'h0000_0004, 32'h1122_3344);
        store(32'h0000_0008, 32'h5566_7788);
        issue(1'b0, 3'b001, 32'h0000_0007, 32'h0);
        chk("slh0_addr", mem_addr, 32'h0000_0004);
        chk("slh0_be", {28'd0, mem_be}, 32'h8);
        tick();
        tick();
        chk("slh1_re", {31'd0, mem_re}, 32'd1);
        chk("slh1_addr", mem_addr, 32'h0000_0008);
        chk("slh1_be", {28'd0, mem_be}, 32'h1);
        tick();
        chk("slh_no_rsp", {31'd0, rsp_valid}, 32'd0);
        tick();
        chk("slh_rsp", {31'd0, rsp_valid}, 32'd1);
        chk("slh_rdata", rsp_rdata, 32'hFFFF_8811);
        tick();

        // 5: illegal funct3 and illegal unsigned store
        issue(1'b0, 3'b011, 32'h0000_0000, 32'h0);
        chk("ill_rsp", {31'd0, rsp_valid}, 32'd1);
        chk("ill_err", {31'd0, rsp_err}, 32'd1);
        chk("ill_rdata", rsp_rdata, 32'h0);
        chk("ill_no_mem", {30'd0, mem_re, mem_we}, 32'd0);
        tick();
        issue(1'b1, 3'b100, 32'h0000_0000, 32'h0);
        chk("ill_st_err", {30'd0, rsp_valid, rsp_err}, 32'd3);
        chk("ill_st_no_we", {31'd0, mem_we}, 32'd0);
        tick();

        // 5b: unit with splitting disabled
        req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_0002; req_valid1 = 1'b1;
        tick();
        req_valid1 = 1'b0;
        chk("rej_rsp", {30'd0, rsp_valid1, rsp_err1}, 32'd3);
        chk("rej_no_mem", {30'd0, mem_re1, mem_we1}, 32'd0);
        chk("rej_rdata", rsp_rdata1, 32'h0);
        tick();
        req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h0000_0001;
        req_wdata = 32'h0000_BEEF; req_valid1 = 1'b1;
        tick();
        req_valid1 = 1'b0;
        chk("nocross_we", {31'd0, mem_we1}, 32'd1);
        chk("nocross_be", {28'd0, mem_be1}, 32'h6);
        chk("nocross_wd", mem_wdata1, 32'h00BE_EF00);
        tick();
        chk("nocross_rsp", {30'd0, rsp_valid1, rsp_err1}, 32'd2);
        tick();

        // 6: reset in the middle of a split load
        issue(1'b0, 3'b001, 32'h0000_0007, 32'h0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);
        chk("mid_rst_rsp", {31'd0, rsp_valid}, 32'd0);
        chk("mid_rst_re", {31'd0, mem_re}, 32'd0);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid) pulses++;
            tick();
        end
        chk("mid_rst_no_pulse", pulses, 32'd0);

        // 6b: address wrap on the second half
        store(32'hFFFF_FFFC, 32'h9ABC_DEF0);
        store(32'h0000_0000, 32'h1357_9BDF);
        issue(1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0);
        chk("wrap0_addr", mem_addr, 32'hFFFF_FFFC);
        chk("wrap0_be", {28'd0, mem_be}, 32'hC);
        tick();
        tick();
        chk("wrap1_addr", mem_addr, 32'h0000_0000);
        chk("wrap1_be", {28'd0, mem_be}, 32'h3);
        tick();
        tick();
        chk("wrap_rsp", {30'd0, rsp_valid, rsp_err}, 32'd2);
        chk("wrap_rdata", rsp_rdata, 32'h9BDF_9ABC);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
